// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - 8N1 character constants, default frame delimiters and frame FSM states
// Shared by uart_byte_tx and uart_frame_tx; no ports.
package uart_pkg;

  localparam logic       START_BIT     = 1'b0;
  localparam logic       STOP_BIT      = 1'b1;
  localparam int         BITS_PER_CHAR = 10;

  localparam logic [7:0] DEF_HEADER    = 8'hFF;
  localparam logic [7:0] DEF_TRAILER   = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } frame_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer with a valid/ready byte input
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   tx_data/tx_valid  byte offered for transmission
//   tx_ready          high when idle or in the last cycle of a stop bit
//   txd               registered serial output, idles high
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = 16'd434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd
);

  logic        active;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic        baud_end;
  logic        char_end;

  assign baud_end = (baud_cnt == BPS_CNT - 16'd1);
  // Last cycle of the stop bit: a new byte accepted here starts its start bit
  // on the very next cycle, so characters run back-to-back.
  assign char_end = active && baud_end && (bit_cnt == 4'(BITS_PER_CHAR - 1));
  assign tx_ready = !active || char_end;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      active   <= 1'b0;
      baud_cnt <= 16'd0;
      bit_cnt  <= 4'd0;
      shreg    <= '1;
      txd      <= STOP_BIT;
    end else if (tx_valid && tx_ready) begin
      active   <= 1'b1;
      baud_cnt <= 16'd0;
      bit_cnt  <= 4'd0;
      shreg    <= {STOP_BIT, tx_data, START_BIT};
      txd      <= START_BIT;
    end else if (char_end) begin
      active   <= 1'b0;
      baud_cnt <= 16'd0;
      bit_cnt  <= 4'd0;
      txd      <= STOP_BIT;
    end else if (active) begin
      if (baud_end) begin
        // shreg[0] is the bit currently on the line; shift in idle level
        baud_cnt <= 16'd0;
        bit_cnt  <= bit_cnt + 4'd1;
        shreg    <= {STOP_BIT, shreg[9:1]};
        txd      <= shreg[1];
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - triggered framed-packet UART transmitter
// Ports:
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   trig              asynchronous frame request, rising edge starts a frame
//   D                 payload, most significant byte sent first
//   addr, mode_sel    source address and mode word, zero-extended to a byte
//   uart_txd          serial line, idles high
//   busy              high from capture until the end of the post-frame gap
//   frame_done        one-cycle pulse when the trailer stop bit completes
//   drop_cnt          saturating count of trigger edges ignored while busy
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT    = 16'd434,
  parameter int          DATA_BYTES = 3,
  parameter bit          CHK_EN     = 1'b1,
  parameter logic [7:0]  HEADER     = DEF_HEADER,
  parameter logic [7:0]  TRAILER    = DEF_TRAILER,
  parameter logic [15:0] GAP_CYC    = 16'd0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    trig,
  input  logic [8*DATA_BYTES-1:0] D,
  input  logic [1:0]              addr,
  input  logic [5:0]              mode_sel,
  output logic                    uart_txd,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              drop_cnt
);

  localparam int         FRAME_LEN = 4 + DATA_BYTES + (CHK_EN ? 1 : 0);
  // Byte index: 0 header, 1 addr, 2 mode, 3.. payload, then checksum, trailer.
  localparam logic [4:0] PAY_FIRST = 5'd3;
  localparam logic [4:0] PAY_END   = 5'(3 + DATA_BYTES);
  localparam logic [4:0] LAST_IDX  = 5'(FRAME_LEN);

  frame_state_t state;

  logic                    trig_s1, trig_s2, trig_s3;
  logic                    trig_edge;
  logic [1:0]              addr_q;
  logic [5:0]              mode_q;
  logic [8*DATA_BYTES-1:0] pay_q;
  logic [7:0]              chk_q;
  logic [4:0]              idx;
  logic [15:0]             gap_cnt;

  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  assign trig_edge = trig_s2 & ~trig_s3;

  // The header is offered straight from LOAD so its start bit follows one
  // cycle later; payload is shifted so the next byte is always the top one.
  assign tx_valid = (state == ST_LOAD) || ((state == ST_SEND) && (idx != LAST_IDX));

  always_comb begin
    tx_data = TRAILER;
    if (state == ST_LOAD) begin
      tx_data = HEADER;
    end else if (idx == 5'd1) begin
      tx_data = {6'b0, addr_q};
    end else if (idx == 5'd2) begin
      tx_data = {2'b0, mode_q};
    end else if (idx < PAY_END) begin
      tx_data = pay_q[8*DATA_BYTES-1 -: 8];
    end else if (CHK_EN && (idx == PAY_END)) begin
      tx_data = chk_q;
    end
  end

  uart_byte_tx #(
    .BPS_CNT(BPS_CNT)
  ) u_byte_tx (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (uart_txd)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      trig_s1    <= 1'b0;
      trig_s2    <= 1'b0;
      trig_s3    <= 1'b0;
      addr_q     <= 2'd0;
      mode_q     <= 6'd0;
      pay_q      <= '0;
      chk_q      <= 8'd0;
      idx        <= 5'd0;
      gap_cnt    <= 16'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      trig_s1    <= trig;
      trig_s2    <= trig_s1;
      trig_s3    <= trig_s2;
      frame_done <= 1'b0;

      if (trig_edge && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (trig_edge) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        ST_LOAD: begin
          addr_q <= addr;
          mode_q <= mode_sel;
          pay_q  <= D;
          chk_q  <= 8'd0;
          // Header is accepted by the idle serializer in this cycle.
          idx    <= 5'd1;
          state  <= ST_SEND;
        end

        ST_SEND: begin
          if (tx_valid && tx_ready) begin
            idx <= idx + 5'd1;
            if (idx < PAY_END) begin
              chk_q <= chk_q ^ tx_data;
            end
            if ((idx >= PAY_FIRST) && (idx < PAY_END)) begin
              pay_q <= pay_q << 8;
            end
          end else if ((idx == LAST_IDX) && tx_ready) begin
            // Trailer stop bit is in its final cycle.
            frame_done <= 1'b1;
            if (GAP_CYC == 16'd0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= 16'd0;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_CYC - 16'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb/tb_uart_frame_tx.sv - randomized self-checking bench for uart_frame_tx
module tb_uart_frame_tx;

  localparam int B  = 4;
  localparam int NL = 2;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic        trig  [NL];
  logic [23:0] d_in  [NL];
  logic [1:0]  addr  [NL];
  logic [5:0]  mode  [NL];
  logic        txd   [NL];
  logic        busy  [NL];
  logic        fdone [NL];
  logic [7:0]  drop  [NL];

  // lane 0: 3 payload bytes, checksum, 10-cycle gap
  uart_frame_tx #(
    .BPS_CNT(16'd4), .DATA_BYTES(3), .CHK_EN(1'b1),
    .HEADER(8'hFF), .TRAILER(8'hAA), .GAP_CYC(16'd10)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .trig(trig[0]), .D(d_in[0]),
    .addr(addr[0]), .mode_sel(mode[0]), .uart_txd(txd[0]), .busy(busy[0]),
    .frame_done(fdone[0]), .drop_cnt(drop[0])
  );

  // lane 1: 1 payload byte, no checksum, no gap
  uart_frame_tx #(
    .BPS_CNT(16'd4), .DATA_BYTES(1), .CHK_EN(1'b0),
    .HEADER(8'hFF), .TRAILER(8'hAA), .GAP_CYC(16'd0)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .trig(trig[1]), .D(d_in[1][7:0]),
    .addr(addr[1]), .mode_sel(mode[1]), .uart_txd(txd[1]), .busy(busy[1]),
    .frame_done(fdone[1]), .drop_cnt(drop[1])
  );

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // line decoders and status monitors, sampled on the falling edge
  int         rx_n      [NL] = '{default: 0};
  logic [7:0] rx_buf    [NL][1024];
  int         rx_start  [NL][1024];
  int         fr_err    [NL] = '{default: 0};
  int         fd_cnt    [NL] = '{default: 0};
  int         fd_cyc    [NL] = '{default: 0};
  int         busy_rise [NL] = '{default: 0};
  int         busy_fall [NL] = '{default: 0};
  logic       busy_prev [NL] = '{default: 1'b0};
  bit         dec_act   [NL] = '{default: 1'b0};
  int         dec_cnt   [NL] = '{default: 0};
  logic [7:0] dec_sh    [NL] = '{default: 8'h00};

  always @(negedge sys_clk) begin
    for (int g = 0; g < NL; g++) begin
      if (fdone[g] === 1'b1) begin
        fd_cnt[g]++;
        fd_cyc[g] = cyc;
      end
      if (busy[g] === 1'b1 && busy_prev[g] !== 1'b1) busy_rise[g] = cyc;
      if (busy[g] === 1'b0 && busy_prev[g] === 1'b1) busy_fall[g] = cyc;
      busy_prev[g] = busy[g];
      if (sys_rst) begin
        dec_act[g] = 1'b0;
      end else if (!dec_act[g]) begin
        if (txd[g] === 1'b0) begin
          dec_act[g] = 1'b1;
          dec_cnt[g] = 0;
          dec_sh[g]  = 8'h00;
          rx_start[g][rx_n[g] % 1024] = cyc;
        end
      end else begin
        dec_cnt[g]++;
        if (dec_cnt[g] >= B + B/2 && dec_cnt[g] <= 8*B + B/2 && (dec_cnt[g] - B/2) % B == 0)
          dec_sh[g] = {txd[g], dec_sh[g][7:1]};
        if (dec_cnt[g] == 9*B + B/2 && txd[g] !== 1'b1) fr_err[g]++;
        if (dec_cnt[g] == 10*B - 1) begin
          rx_buf[g][rx_n[g] % 1024] = dec_sh[g];
          rx_n[g]++;
          dec_act[g] = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // reference frame built from the byte-order and checksum rules
  logic [7:0] exp_f [32];
  int         exp_n;
  int         exp_drop [NL] = '{default: 0};

  task automatic build_frame(input int g, input logic [23:0] d, input logic [1:0] a, input logic [5:0] m);
    int         db;
    logic [7:0] x;
    logic [7:0] b;
    db = (g == 0) ? 3 : 1;
    exp_n = 0;
    exp_f[exp_n] = 8'hFF;        exp_n++;
    exp_f[exp_n] = {6'b0, a};    exp_n++;
    exp_f[exp_n] = {2'b0, m};    exp_n++;
    x = {6'b0, a} ^ {2'b0, m};
    for (int i = db - 1; i >= 0; i--) begin
      b = d[8*i +: 8];
      exp_f[exp_n] = b;          exp_n++;
      x = x ^ b;
    end
    if (g == 0) begin
      exp_f[exp_n] = x;          exp_n++;
    end
    exp_f[exp_n] = 8'hAA;        exp_n++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_done(input int g, input int n0, input string tag);
    int k = 0;
    while (fd_cnt[g] == n0 && k < 2000) begin
      tick();
      k++;
    end
    if (fd_cnt[g] == n0) check({tag, " done_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input int g, input string tag);
    int k = 0;
    while (busy[g] !== 1'b0 && k < 2000) begin
      tick();
      k++;
    end
    if (busy[g] !== 1'b0) check({tag, " idle_timeout"}, 0, 1);
    repeat (4) tick();
  endtask

  task automatic pulse(input int g, input int hi);
    trig[g] = 1'b1;
    repeat (hi) tick();
    trig[g] = 1'b0;
  endtask

  task automatic check_frame(input int g, input int base, input logic [23:0] d,
                             input logic [1:0] a, input logic [5:0] m, input string tag);
    build_frame(g, d, a, m);
    check({tag, " len"}, rx_n[g] - base, exp_n);
    for (int i = 0; i < exp_n; i++)
      check($sformatf("%s byte%0d", tag, i), rx_buf[g][(base + i) % 1024], exp_f[i]);
    check({tag, " dur"}, fd_cyc[g] - rx_start[g][base % 1024], 10 * B * exp_n);
  endtask

  task automatic run_frame(input int g, input logic [23:0] d, input logic [1:0] a,
                           input logic [5:0] m, input string tag);
    int base, n0, t0, lat;
    d_in[g] = d; addr[g] = a; mode[g] = m;
    base = rx_n[g]; n0 = fd_cnt[g]; t0 = cyc;
    pulse(g, 2);
    wait_done(g, n0, tag);
    check_frame(g, base, d, a, m, tag);
    lat = rx_start[g][base % 1024] - t0;
    check({tag, " trig_latency_ok"}, (lat >= 3 && lat <= 5) ? 1 : 0, 1);
    check({tag, " busy_lead"}, rx_start[g][base % 1024] - busy_rise[g], 1);
    check({tag, " drop"}, drop[g], exp_drop[g]);
    wait_idle(g, tag);
    check({tag, " busy_tail"}, busy_fall[g] - fd_cyc[g], (g == 0) ? 10 : 1);
  endtask

  initial begin
    int base, n0, n1, f, k;
    logic [23:0] d;
    logic [1:0]  a;
    logic [5:0]  m;

    for (int g = 0; g < NL; g++) begin
      trig[g] = 1'b0; d_in[g] = 24'h0; addr[g] = 2'd0; mode[g] = 6'd0;
    end

    repeat (3) tick();
    sys_rst = 1'b0;
    for (int g = 0; g < NL; g++) begin
      check($sformatf("rst txd%0d", g), txd[g], 1);
      check($sformatf("rst busy%0d", g), busy[g], 0);
      check($sformatf("rst done%0d", g), fdone[g], 0);
      check($sformatf("rst drop%0d", g), drop[g], 0);
    end
    repeat (5) tick();

    run_frame(0, 24'h123456, 2'd2, 6'h15, "basic");
    run_frame(1, 24'h0000C3, 2'd1, 6'h00, "nochk");
    for (int i = 0; i < 3; i++) begin
      run_frame(0, 24'($urandom()), 2'($urandom()), 6'($urandom()), $sformatf("randA%0d", i));
      run_frame(1, 24'($urandom()), 2'($urandom()), 6'($urandom()), $sformatf("randB%0d", i));
    end

    // extra trigger pulses while the frame is in flight
    d = 24'($urandom()); a = 2'($urandom()); m = 6'($urandom());
    d_in[0] = d; addr[0] = a; mode[0] = m;
    base = rx_n[0]; n0 = fd_cnt[0];
    pulse(0, 2);
    repeat (40) tick();
    for (int i = 0; i < 3; i++) begin
      pulse(0, 3);
      repeat (3) tick();
    end
    exp_drop[0] += 3;
    wait_done(0, n0, "ovl");
    check_frame(0, base, d, a, m, "ovl");
    wait_idle(0, "ovl");
    check("ovl frames", fd_cnt[0] - n0, 1);
    check("ovl drop", drop[0], exp_drop[0]);

    // trigger inside the gap is dropped, one just after it is accepted
    d = 24'($urandom()); a = 2'($urandom()); m = 6'($urandom());
    d_in[0] = d; addr[0] = a; mode[0] = m;
    base = rx_n[0]; n0 = fd_cnt[0];
    pulse(0, 2);
    wait_done(0, n0, "gap1");
    check_frame(0, base, d, a, m, "gap1");
    f = fd_cyc[0];
    while (cyc < f + 5) tick();
    pulse(0, 2);
    exp_drop[0] += 1;
    d = 24'($urandom()); a = 2'($urandom()); m = 6'($urandom());
    d_in[0] = d; addr[0] = a; mode[0] = m;
    base = rx_n[0]; n1 = fd_cnt[0];
    while (cyc < f + 11) tick();
    pulse(0, 2);
    wait_done(0, n1, "gap2");
    check_frame(0, base, d, a, m, "gap2");
    check("gap drop", drop[0], exp_drop[0]);
    check("gap frames", fd_cnt[0] - n0, 2);
    wait_idle(0, "gap2");

    // trig held high with inputs changing mid-frame
    d = 24'($urandom()); a = 2'($urandom()); m = 6'($urandom());
    d_in[0] = d; addr[0] = a; mode[0] = m;
    base = rx_n[0]; n0 = fd_cnt[0];
    trig[0] = 1'b1;
    repeat (100) tick();
    d_in[0] = ~d; addr[0] = ~a; mode[0] = ~m;
    wait_done(0, n0, "hold");
    check_frame(0, base, d, a, m, "hold");
    repeat (60) tick();
    check("hold frames", fd_cnt[0] - n0, 1);
    check("hold drop", drop[0], exp_drop[0]);
    trig[0] = 1'b0;
    wait_idle(0, "hold");

    // reset during the payload
    d = 24'($urandom()); a = 2'($urandom()); m = 6'($urandom());
    d_in[0] = d; addr[0] = a; mode[0] = m;
    base = rx_n[0]; n0 = fd_cnt[0];
    pulse(0, 2);
    k = 0;
    while (rx_n[0] - base < 4 && k < 2000) begin
      tick();
      k++;
    end
    check("mid_rst reached_payload", (rx_n[0] - base >= 4) ? 1 : 0, 1);
    repeat (5) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    exp_drop[0] = 0; exp_drop[1] = 0;
    check("mid_rst txd", txd[0], 1);
    check("mid_rst busy", busy[0], 0);
    check("mid_rst drop", drop[0], 0);
    repeat (400) tick();
    check("mid_rst no_done", fd_cnt[0] - n0, 0);
    check("mid_rst line_idle", txd[0], 1);
    run_frame(0, 24'($urandom()), 2'($urandom()), 6'($urandom()), "post_rst");

    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      pulse(0, 3);
      repeat (3) tick();
    end
    repeat (5) tick();
    wait_idle(0, "sat");
    check("sat drop", drop[0], 255);
    check("lane1 drop", drop[1], exp_drop[1]);
    check("framing0", fr_err[0], 0);
    check("framing1", fr_err[1], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
